mac_arbiter: RTL and testbench
==============================

Name: mac_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multiply-accumulate datapath (data_out = a*b + c) among NREQ requesters. It grants one requester at a time and latches that requester's a, b and c operands. It streams the operands into the datapath as exactly three consecutive validi beats, then waits for valido and returns data_out to the owning requester. It sits between the requester ports and the datapath's validi/data_in/valido/data_out interface.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, operand/result width; matches datapath data_in/data_out
TIMEOUT, 4, max cycles in WAIT for valido before error response (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request; held with operands stable until gnt
a_in  input  NREQ*DW  operand a, requester i at bits [i*DW +: DW]
b_in  input  NREQ*DW  operand b, same packing
c_in  input  NREQ*DW  operand c, same packing
gnt  output  NREQ  one-hot, 1-cycle pulse; operands of that requester consumed
rsp_valid  output  NREQ  one-hot, 1-cycle pulse; result for that requester
rsp_data  output  DW  result, valid while any rsp_valid bit is high, else 0
rsp_err  output  1  qualifies rsp_valid: 1 = timeout, rsp_data = 0
validi  output  1  datapath input valid
data_in  output  DW  datapath operand
valido  input  1  datapath result valid
data_out  input  DW  datapath result
busy  output  1  1 in every state except IDLE
spurious  output  1  sticky: valido seen outside WAIT; cleared only by reset

Behaviour:
- Reset (rst=0, async): state IDLE; gnt, rsp_valid, rsp_err, validi, busy, spurious = 0; data_in, rsp_data = 0; RR pointer = NREQ-1, so req[0] has top priority. Any in-flight transaction is dropped; no response is issued.
- All outputs are registered.
- FSM states: IDLE, OP_A, OP_B, OP_C, WAIT, RESP.
- IDLE: if any req bit is set, pick the first set bit searching from pointer+1 modulo NREQ. Latch its a/b/c and owner index, set pointer = owner, pulse gnt[owner] for the next cycle, then go to OP_A. With no req, stay in IDLE.
- OP_A/OP_B/OP_C: validi=1 with data_in = a, b, c respectively, one state per cycle. That gives exactly 3 consecutive validi beats. validi is 0 in every other state; data_in is 0 when validi=0.
- WAIT: entered the cycle after OP_C. The datapath asserts valido on the first WAIT cycle.
  - On valido=1: capture data_out, go to RESP with err=0.
  - After TIMEOUT WAIT cycles without valido: go to RESP with err=1 and data 0.
- RESP: rsp_valid[owner]=1 and rsp_data/rsp_err driven for one cycle, then return to IDLE.
- Gaps: validi is low for at least 3 cycles between bursts (WAIT, RESP, IDLE). Minimum period is 6 cycles per transaction.
- Latency: req sampled in IDLE at edge t; gnt high in cycle t+1 (coincides with OP_A); rsp_valid high in cycle t+5 in the nominal case.
- Arithmetic: no arithmetic in this block. data_out is passed through unchanged; wrap mod 2^DW is a datapath property.
- valido in any state other than WAIT sets spurious and is otherwise ignored.
- A second valido within the same WAIT cannot occur, because WAIT exits on the first one.
- req changes after gnt do not affect the running transaction. req deasserted before being sampled in IDLE is never granted.
- Simultaneous requests: only one is granted per IDLE visit. The others wait; starvation-free, with a bound of NREQ transactions.

Test Plan:
- req[0]=1, a=3, b=4, c=5; datapath model returns 17 → gnt[0] in 1 cycle; data_in = 3,4,5 on 3 consecutive validi cycles; rsp_valid[0]=1, rsp_data=17, rsp_err=0, 5 cycles after sampling.
- req[0] and req[2] held continuously → grant order 0,2,0,2; validi never high for more than 3 consecutive cycles; low at least 3 cycles between bursts.
- Datapath model never asserts valido, TIMEOUT=4 → 4 WAIT cycles, then rsp_valid[owner]=1, rsp_err=1, rsp_data=0; FSM returns to IDLE.
- valido pulsed while in IDLE → spurious=1 and stays 1; the next normal transaction still completes correctly.
- rst driven low during OP_B → validi, gnt, busy are 0 immediately (asynchronous); no rsp_valid follows; after release, req[0] is granted first.
- a=0xFFFFFFFF, b=2, c=1; model returns wrapped 0xFFFFFFFF → rsp_data=0xFFFFFFFF, passed through unchanged.

Source files
------------

// File: rtl/mac_arbiter.sv
// Round-robin front end for a shared a*b+c datapath: grants one requester at a time,
// streams its operands as three validi beats and routes the result back to the owner.
module mac_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   a_in,
  input  logic [NREQ*DW-1:0]   b_in,
  input  logic [NREQ*DW-1:0]   c_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_err,
  output logic                 validi,
  output logic [DW-1:0]        data_in,
  input  logic                 valido,
  input  logic [DW-1:0]        data_out,
  output logic                 busy,
  output logic                 spurious
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OP_A = 3'd1;
  localparam logic [2:0] S_OP_B = 3'd2;
  localparam logic [2:0] S_OP_C = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]      state_r, state_s;
  logic [IW-1:0]   ptr_r, ptr_s, owner_r, owner_s, pick_s, idx_s;
  logic            found_s, grant_s, err_s;
  logic [DW-1:0]   b_r, b_s, c_r, c_s, res_s, data_in_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [NREQ-1:0] owner_hot_s;
  logic [DW-1:0]   a_arr [NREQ];
  logic [DW-1:0]   b_arr [NREQ];
  logic [DW-1:0]   c_arr [NREQ];

  logic [NREQ-1:0] gnt_r, rsp_valid_r;
  logic [DW-1:0]   rsp_data_r, data_in_r;
  logic            rsp_err_r, validi_r, busy_r, spurious_r;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = a_in[g*DW +: DW];
    assign b_arr[g] = b_in[g*DW +: DW];
    assign c_arr[g] = c_in[g*DW +: DW];
  end

  // Round-robin pick: scan from lowest to highest priority so the last hit wins
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IW{1'b0}};
    idx_s   = {IW{1'b0}};
    for (int i = NREQ; i >= 1; i--) begin
      idx_s   = IW'((int'(ptr_r) + i) % NREQ);
      pick_s  = req[idx_s] ? idx_s : pick_s;
      found_s = found_s | req[idx_s];
    end
  end

  // Next-state and transaction bookkeeping
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    b_s     = b_r;
    c_s     = c_r;
    cnt_s   = cnt_r;
    grant_s = 1'b0;
    res_s   = {DW{1'b0}};
    err_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          state_s = S_OP_A;
          ptr_s   = pick_s;
          owner_s = pick_s;
          b_s     = b_arr[pick_s];
          c_s     = c_arr[pick_s];
          grant_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_OP_A: state_s = S_OP_B;
      S_OP_B: state_s = S_OP_C;
      S_OP_C: begin
        state_s = S_WAIT;
        cnt_s   = {CW{1'b0}};
      end
      S_WAIT: begin
        if (valido) begin
          state_s = S_RESP;
          res_s   = data_out;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          state_s = S_RESP;
          err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath operand for the beat about to be presented; operand a comes straight from the port
  always_comb begin
    owner_hot_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_s;
    case (state_s)
      S_OP_A:  data_in_s = a_arr[pick_s];
      S_OP_B:  data_in_s = b_r;
      S_OP_C:  data_in_s = c_r;
      default: data_in_s = {DW{1'b0}};
    endcase
  end

  // State, latched operands and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      ptr_r       <= IW'(NREQ - 1);
      owner_r     <= {IW{1'b0}};
      b_r         <= {DW{1'b0}};
      c_r         <= {DW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      gnt_r       <= {NREQ{1'b0}};
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_data_r  <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
      validi_r    <= 1'b0;
      data_in_r   <= {DW{1'b0}};
      busy_r      <= 1'b0;
      spurious_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      owner_r     <= owner_s;
      b_r         <= b_s;
      c_r         <= c_s;
      cnt_r       <= cnt_s;
      gnt_r       <= grant_s ? owner_hot_s : {NREQ{1'b0}};
      rsp_valid_r <= (state_s == S_RESP) ? owner_hot_s : {NREQ{1'b0}};
      rsp_data_r  <= res_s;
      rsp_err_r   <= err_s;
      validi_r    <= (state_s == S_OP_A) || (state_s == S_OP_B) || (state_s == S_OP_C);
      data_in_r   <= data_in_s;
      busy_r      <= (state_s != S_IDLE);
      spurious_r  <= spurious_r | (valido & (state_r != S_WAIT));
    end
  end

  assign gnt       = gnt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign validi    = validi_r;
  assign data_in   = data_in_r;
  assign busy      = busy_r;
  assign spurious  = spurious_r;

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mac_arbiter;
  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*DW-1:0]  a_in = '0;
  logic [NREQ*DW-1:0]  b_in = '0;
  logic [NREQ*DW-1:0]  c_in = '0;
  logic [NREQ-1:0]     gnt, rsp_valid;
  logic [DW-1:0]       rsp_data, data_in;
  logic                rsp_err, validi, busy, spurious;
  logic                valido = 1'b0;
  logic [DW-1:0]       data_out = '0;

  mac_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .validi(validi), .data_in(data_in), .valido(valido), .data_out(data_out),
    .busy(busy), .spurious(spurious)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  // requester side
  logic [DW-1:0] op_a [NREQ];
  logic [DW-1:0] op_b [NREQ];
  logic [DW-1:0] op_c [NREQ];
  bit hold_req [NREQ];
  bit auto_req = 1'b0;

  // reference model: one transaction described by its grant edge and response edge
  bit in_txn, merr, mspur;
  int ptr, owner, g_e, r_e, free_e, dly;
  int dly_mode = 0;
  logic [DW-1:0] ma, mb, mc;
  logic [DW-1:0] beat [3];
  int dut_gnt_log[$];
  bit vhist[$];
  bit rec_hist = 1'b0;
  int at_e, t0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic pack_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*DW +: DW] = op_a[i];
      b_in[i*DW +: DW] = op_b[i];
      c_in[i*DW +: DW] = op_c[i];
    end
  endtask

  task automatic model_reset();
    in_txn = 1'b0;
    merr   = 1'b0;
    mspur  = 1'b0;
    ptr    = NREQ - 1;
    free_e = 0;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] rq, input logic vo);
    int j;
    bit found;
    if (vo && !(in_txn && edge_n >= g_e + 4 && edge_n <= r_e)) mspur = 1'b1;
    if (in_txn && edge_n > r_e) in_txn = 1'b0;
    if (!in_txn && edge_n >= free_e && rq != '0) begin
      found = 1'b0;
      for (int s = 1; s <= NREQ; s++) begin
        j = (ptr + s) % NREQ;
        if (!found && rq[j]) begin
          found = 1'b1;
          owner = j;
        end
      end
      ptr    = owner;
      ma     = op_a[owner];
      mb     = op_b[owner];
      mc     = op_c[owner];
      g_e    = edge_n;
      dly    = (dly_mode < 0) ? int'($urandom_range(0, TIMEOUT + 1)) : dly_mode;
      merr   = (dly >= TIMEOUT);
      r_e    = merr ? g_e + 3 + TIMEOUT : g_e + 4 + dly;
      free_e = r_e + 2;
      in_txn = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    logic [NREQ-1:0] xg, xr;
    logic            xv, xe, xb;
    logic [DW-1:0]   xd, xrd;
    int              k;
    xg = '0; xr = '0; xv = 1'b0; xe = 1'b0; xb = 1'b0; xd = '0; xrd = '0;
    if (rst && in_txn) begin
      k  = edge_n - g_e;
      xb = 1'b1;
      if (k == 0) xg = NREQ'(1) << owner;
      if (k >= 0 && k <= 2) begin
        xv = 1'b1;
        xd = (k == 0) ? ma : (k == 1) ? mb : mc;
      end
      if (edge_n == r_e) begin
        xr  = NREQ'(1) << owner;
        xe  = merr;
        xrd = merr ? '0 : ma * mb + mc;
      end
    end
    check("gnt", gnt, xg);
    check("validi", validi, xv);
    check("data_in", data_in, xd);
    check("rsp_valid", rsp_valid, xr);
    check("rsp_data", rsp_data, xrd);
    check("rsp_err", rsp_err, xe);
    check("busy", busy, xb);
    check("spurious", spurious, mspur);
  endtask

  task automatic drive_next();
    int k;
    if (rst && in_txn) begin
      k = edge_n - g_e;
      if (k >= 0 && k <= 2) beat[k] = data_in;
      valido   = !merr && (edge_n == g_e + 3 + dly);
      data_out = beat[0] * beat[1] + beat[2];
    end else begin
      valido   = 1'b0;
      data_out = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (rst && in_txn && edge_n == g_e && owner == i && !hold_req[i]) begin
        req[i] = 1'b0;
      end else if (auto_req && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i]  = 1'b1;
        op_a[i] = $urandom;
        op_b[i] = $urandom;
        op_c[i] = $urandom;
      end
    end
    pack_ops();
  endtask

  task automatic step();
    logic [NREQ-1:0] req_at;
    logic            vo_at;
    req_at = req;
    vo_at  = valido;
    @(posedge clk);
    #1;
    edge_n++;
    if (rst) model_edge(req_at, vo_at);
    compare_outputs();
    if (rec_hist) vhist.push_back(validi);
    for (int i = 0; i < NREQ; i++) if (gnt[i]) dut_gnt_log.push_back(i);
    drive_next();
  endtask

  task automatic wait_rsp(input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget && at < 0; n++) begin
      step();
      if (rsp_valid != '0) at = edge_n;
    end
    if (at < 0) check("rsp_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    auto_req = 1'b0;
    for (int i = 0; i < NREQ; i++) hold_req[i] = 1'b0;
    req    = '0;
    valido = 1'b0;
    rst    = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = c;
    pack_ops();
    req[i] = 1'b1;
  endtask

  initial begin
    int exp_order[4];
    int run, maxrun, z, mingap;
    bit seen;
    exp_order = '{0, 2, 0, 2};
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_c[i] = '0;
    end
    model_reset();

    // nominal transaction: 3*4+5
    do_reset();
    dly_mode = 0;
    set_op(0, 32'd3, 32'd4, 32'd5);
    t0 = edge_n + 1;
    step();
    check("d1_gnt", gnt, 4'b0001);
    check("d1_beat_a", data_in, 32'd3);
    step();
    check("d1_beat_b", data_in, 32'd4);
    step();
    check("d1_beat_c", data_in, 32'd5);
    wait_rsp(20, at_e);
    check("d1_latency", at_e - t0, 64'd4);
    check("d1_data", rsp_data, 32'd17);
    check("d1_err", rsp_err, 1'b0);

    // two requesters held continuously
    do_reset();
    hold_req[0] = 1'b1;
    hold_req[2] = 1'b1;
    set_op(0, 32'd2, 32'd3, 32'd4);
    set_op(2, 32'd5, 32'd6, 32'd7);
    dut_gnt_log.delete();
    vhist.delete();
    rec_hist = 1'b1;
    repeat (24) step();
    rec_hist = 1'b0;
    hold_req[0] = 1'b0;
    hold_req[2] = 1'b0;
    req = '0;
    repeat (8) step();
    check("d2_grant_count", dut_gnt_log.size(), 64'd4);
    for (int i = 0; i < 4 && i < dut_gnt_log.size(); i++) check("d2_order", dut_gnt_log[i], exp_order[i]);
    run = 0; maxrun = 0; z = 0; mingap = 1000; seen = 1'b0;
    foreach (vhist[i]) begin
      if (vhist[i]) begin
        if (run == 0 && seen && z < mingap) mingap = z;
        run++;
        if (run > maxrun) maxrun = run;
        z = 0;
      end else begin
        if (run > 0) seen = 1'b1;
        run = 0;
        z++;
      end
    end
    check("d2_max_burst", maxrun, 64'd3);
    check("d2_min_gap", mingap, 64'd3);

    // datapath never answers
    do_reset();
    dly_mode = TIMEOUT + 5;
    set_op(1, 32'd11, 32'd12, 32'd13);
    t0 = edge_n + 1;
    wait_rsp(30, at_e);
    check("d3_latency", at_e - t0, 64'd7);
    check("d3_err", rsp_err, 1'b1);
    check("d3_data", rsp_data, 32'd0);
    check("d3_owner", rsp_valid, 4'b0010);
    step();
    check("d3_idle", busy, 1'b0);

    // valido while idle
    do_reset();
    dly_mode = 1;
    valido   = 1'b1;
    data_out = 32'hDEAD_BEEF;
    step();
    check("d4_spur_set", spurious, 1'b1);
    set_op(2, 32'd6, 32'd7, 32'd8);
    wait_rsp(30, at_e);
    check("d4_data", rsp_data, 32'd50);
    check("d4_err", rsp_err, 1'b0);
    repeat (3) step();
    check("d4_spur_sticky", spurious, 1'b1);

    // result wraps in the datapath and is passed through unchanged
    do_reset();
    dly_mode = 0;
    set_op(3, 32'hFFFF_FFFF, 32'd2, 32'd1);
    wait_rsp(20, at_e);
    check("d5_wrap", rsp_data, 32'hFFFF_FFFF);

    // asynchronous reset in the middle of the operand burst
    do_reset();
    dly_mode = 0;
    set_op(1, 32'd9, 32'd10, 32'd11);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("d6_validi", validi, 1'b0);
    check("d6_gnt", gnt, 4'b0000);
    check("d6_busy", busy, 1'b0);
    model_reset();
    valido = 1'b0;
    set_op(0, 32'd1, 32'd2, 32'd3);
    set_op(1, 32'd4, 32'd5, 32'd6);
    set_op(3, 32'd7, 32'd8, 32'd9);
    step();
    step();
    rst = 1'b1;
    step();
    check("d6_first_after_reset", gnt, 4'b0001);
    repeat (20) step();

    // randomized traffic
    do_reset();
    dly_mode = -1;
    auto_req = 1'b1;
    repeat (3000) step();
    auto_req = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
